// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
// Includes the LFSR step used when BURST_MEM_BUBBLE_EN is defined.
package burst_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAT     = 3'd1,
        RD_BEAT = 3'd2,
        WR_BEAT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam int LINE_W = 256;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        logic [7:0] nxt;
        nxt = {1'b0, cur[7:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/burst_mem_if.sv
// Line-burst bus between the cacheline adapter (master) and the memory responder (slave).
interface burst_mem_if;

    logic [31:0]                      address_i;
    logic                             read_i;
    logic                             write_i;
    logic [burst_mem_pkg::BEAT_W-1:0] burst_i;
    logic [burst_mem_pkg::BEAT_W-1:0] burst_o;
    logic                             resp_o;

    modport master (
        output address_i, read_i, write_i, burst_i,
        input  burst_o, resp_o
    );

    modport slave (
        input  address_i, read_i, write_i, burst_i,
        output burst_o, resp_o
    );

endinterface

// File: rtl/burst_mem_lfsr.sv
// Free-running 8-bit Galois LFSR that decides bubble cycles when
// BURST_MEM_BUBBLE_EN is defined.
module burst_mem_lfsr
    import burst_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_r;

    // Advance one step every cycle, reseed on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign lfsr_o = lfsr_r;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for 4-beat x 64-bit line bursts with programmable latency.
// Optional random beat bubbles are enabled by defining BURST_MEM_BUBBLE_EN.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic      clk,
    input  logic      reset_n,
    burst_mem_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH_LINES);
    localparam int         WORDS    = DEPTH_LINES * BEATS;
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    state_t            state_r, state_s;
    logic [7:0]        lat_cnt_r, lat_cnt_s;
    logic [1:0]        beat_r, beat_s;
    logic              is_wr_r, is_wr_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              bubble_s;
    logic              req_ok_s;
    logic              resp_s;
    logic              wr_en_s;
    logic [IDX_W+1:0]  word_addr_s;
    logic [BEAT_W-1:0] mem_r [WORDS];

`ifdef BURST_MEM_BUBBLE_EN
    logic [7:0] lfsr_s;
    logic       unused_lfsr_s;

    burst_mem_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr_o  (lfsr_s)
    );

    assign bubble_s      = lfsr_s[0];
    assign unused_lfsr_s = ^lfsr_s[7:1];
`else
    assign bubble_s = 1'b0;
`endif

    // The burst stays alive only while the initiator keeps its own direction asserted
    assign req_ok_s    = is_wr_r ? bus.write_i : bus.read_i;
    assign word_addr_s = {idx_r, beat_r};

    // Next-state and beat strobe decode
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        beat_s    = beat_r;
        is_wr_s   = is_wr_r;
        idx_s     = idx_r;
        resp_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.read_i || bus.write_i) begin
                    is_wr_s   = !bus.read_i;
                    idx_s     = bus.address_i[5 +: IDX_W];
                    lat_cnt_s = LAT_LOAD;
                    beat_s    = 2'd0;
                    if (LATENCY == 1) begin
                        state_s = bus.read_i ? RD_BEAT : WR_BEAT;
                    end else begin
                        state_s = LAT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LAT: begin
                if (!req_ok_s) begin
                    state_s = IDLE;
                end else begin
                    lat_cnt_s = lat_cnt_r - 8'd1;
                    if (lat_cnt_r == 8'd1) begin
                        state_s = is_wr_r ? WR_BEAT : RD_BEAT;
                    end else begin
                        state_s = LAT;
                    end
                end
            end
            RD_BEAT, WR_BEAT: begin
                if (!req_ok_s) begin
                    state_s = IDLE;
                end else if (bubble_s) begin
                    state_s = state_r;
                end else begin
                    resp_s = 1'b1;
                    beat_s = beat_r + 2'd1;
                    if (beat_r == 2'd3) begin
                        state_s = DONE;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            lat_cnt_r <= 8'd0;
            beat_r    <= 2'd0;
            is_wr_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_s;
            lat_cnt_r <= lat_cnt_s;
            beat_r    <= beat_s;
            is_wr_r   <= is_wr_s;
            idx_r     <= idx_s;
        end
    end

    assign wr_en_s = resp_s && (state_r == WR_BEAT);

    // Word array: contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[word_addr_s] <= bus.burst_i;
        end
    end

    assign bus.resp_o  = resp_s;
    assign bus.burst_o = (resp_s && (state_r == RD_BEAT)) ? mem_r[word_addr_s] : {BEAT_W{1'b0}};

    logic unused_addr_s;
    assign unused_addr_s = ^{bus.address_i[31:5+IDX_W], bus.address_i[4:0]};

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: table-driven bursts, corner sequences
// and a random phase, with read data checked through a scoreboard queue.
module tb_burst_mem_responder;
    import burst_mem_pkg::*;

    localparam int LATENCY_C = 4;
    localparam int DL        = 256;

    typedef logic [3:0][63:0] line_t;
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        line_t       wdata;
        line_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          n_pass = 0;
    int          n_total = 0;
    int          bubbles = 0;
    logic [63:0] model [DL*4];
    logic [63:0] exp_q [$];
    vec_t        vecs [11];

    burst_mem_if bus ();

    burst_mem_responder #(.LATENCY(LATENCY_C), .DEPTH_LINES(DL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic line_t line4(input logic [63:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic line_t model_line(input int idx);
        line_t l;
        for (int i = 0; i < 4; i++) l[i] = model[idx*4 + i];
        return l;
    endfunction

    // One burst starting in an IDLE cycle; abort_at = beat count at which the request is dropped
    task automatic burst(input bit rd, input bit wr, input logic [31:0] addr, input line_t wdata,
                         input line_t exp, input int abort_at, input string tag);
        int         beats = 0;
        int         first = -1;
        int         last = -1;
        bit         done = 1'b0;
        logic [7:0] idx = addr[12:5];
        if (rd) for (int i = 0; i < 4; i++) exp_q.push_back(exp[i]);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            tick();
            if (beats == abort_at) begin
                bus.read_i  = 1'b0;
                bus.write_i = 1'b0;
            end else begin
                bus.read_i    = rd;
                bus.write_i   = wr;
                bus.address_i = (cyc == 0) ? addr : ~addr;
            end
            bus.burst_i = (beats < 4) ? wdata[beats] : 64'h0;
            #1;
            if (beats == abort_at) begin
                check({tag, "_abort_resp"}, bus.resp_o, 1'b0);
                exp_q.delete();
                return;
            end
            if (beats == 4) begin
                check({tag, "_done_resp"}, bus.resp_o, 1'b0);
                check({tag, "_done_burst_o"}, bus.burst_o, 64'h0);
                done = 1'b1;
            end else if (bus.resp_o) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (rd) check({tag, "_rdata"}, bus.burst_o, exp_q.pop_front());
                else model[{idx, beats[1:0]}] = wdata[beats];
                beats++;
            end else begin
                check({tag, "_idle_burst_o"}, bus.burst_o, 64'h0);
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: got %0d beats, required 4", tag, beats);
        end else begin
`ifdef BURST_MEM_BUBBLE_EN
            bubbles += (first - LATENCY_C) + (last - first - 3);
            check({tag, "_first_ge_lat"}, 64'(first >= LATENCY_C), 64'd1);
`else
            check({tag, "_first_beat"}, 64'(first), 64'(LATENCY_C));
            check({tag, "_beat_span"}, 64'(last - first), 64'd3);
`endif
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    initial begin
        line_t h = line4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                         64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        line_t d = line4(64'h0000_0000_000D_EAD0, 64'h0000_0000_000D_EAD1,
                         64'h0000_0000_000D_EAD2, 64'h0000_0000_000D_EAD3);
        line_t a = line4(64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
                         64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3);
        line_t b = line4(64'hB0B0_0000_0000_00B0, 64'hB1B1_0000_0000_00B1,
                         64'hB2B2_0000_0000_00B2, 64'hB3B3_0000_0000_00B3);
        line_t j = line4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                         64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC);
        line_t z = '0;

        vecs[0]  = '{rd:1'b0, wr:1'b1, addr:32'h0000_0000, wdata:h, exp:z};
        vecs[1]  = '{rd:1'b1, wr:1'b0, addr:32'h0000_0000, wdata:z, exp:h};
        vecs[2]  = '{rd:1'b0, wr:1'b1, addr:32'h0000_0020, wdata:d, exp:z};
        vecs[3]  = '{rd:1'b1, wr:1'b0, addr:32'h0000_0020, wdata:z, exp:d};
        vecs[4]  = '{rd:1'b1, wr:1'b0, addr:32'h0000_0000, wdata:z, exp:h};
        vecs[5]  = '{rd:1'b1, wr:1'b1, addr:32'h0000_0020, wdata:j, exp:d};
        vecs[6]  = '{rd:1'b1, wr:1'b0, addr:32'h0000_0020, wdata:z, exp:d};
        vecs[7]  = '{rd:1'b0, wr:1'b1, addr:32'hFFFF_FFE0, wdata:a, exp:z};
        vecs[8]  = '{rd:1'b1, wr:1'b0, addr:32'h0000_1FFF, wdata:z, exp:a};
        vecs[9]  = '{rd:1'b0, wr:1'b1, addr:32'h0000_2000, wdata:b, exp:z};
        vecs[10] = '{rd:1'b1, wr:1'b0, addr:32'h0000_0000, wdata:z, exp:b};

        reset_n       = 1'b0;
        bus.address_i = 32'h0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = 64'h0;
        #1;
        check("reset_resp", bus.resp_o, 1'b0);
        check("reset_burst_o", bus.burst_o, 64'h0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            burst(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, -1,
                  $sformatf("vec%0d", i));

        // read dropped after two beats, then an immediate normal read
        burst(1'b1, 1'b0, 32'h0000_0020, z, d, 2, "rd_abort");
        burst(1'b1, 1'b0, 32'h0000_0000, z, b, -1, "after_abort");

        // write dropped after one committed beat
        burst(1'b0, 1'b1, 32'h0000_0020, j, z, 1, "wr_abort");
        burst(1'b1, 1'b0, 32'h0000_0020, z, line4(j[0], d[1], d[2], d[3]), -1, "wr_abort_rd");

        // reset pulsed mid-latency
        tick();
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_lat_resp", bus.resp_o, 1'b0);
        check("rst_lat_burst_o", bus.burst_o, 64'h0);
        bus.read_i = 1'b0;
        tick();
        reset_n = 1'b1;

        // reset pulsed during a read beat
        tick();
        bus.read_i = 1'b1;
        #1;
        for (int c = 0; c < 50 && !bus.resp_o; c++) begin
            tick();
            #1;
        end
        check("rst_beat_pre_resp", bus.resp_o, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_beat_resp", bus.resp_o, 1'b0);
        check("rst_beat_burst_o", bus.burst_o, 64'h0);
        bus.read_i = 1'b0;
        tick();
        reset_n = 1'b1;
        burst(1'b1, 1'b0, 32'h0000_0000, z, model_line(0), -1, "post_rst");

        // random phase over lines 0..7
        for (int l = 0; l < 8; l++)
            burst(1'b0, 1'b1, 32'(l) << 5,
                  line4({$urandom, $urandom}, {$urandom, $urandom},
                        {$urandom, $urandom}, {$urandom, $urandom}), z, -1, "pre");
        for (int n = 0; n < 100; n++) begin
            int          l  = $urandom_range(0, 7);
            bit          rd = 1'($urandom_range(0, 1));
            logic [31:0] ad = ($urandom() & 32'hFFFF_E01F) | (32'(l) << 5);
            line_t       wd = line4({$urandom, $urandom}, {$urandom, $urandom},
                                    {$urandom, $urandom}, {$urandom, $urandom});
            burst(rd, !rd, ad, wd, model_line(l), -1, "rnd");
        end
`ifdef BURST_MEM_BUBBLE_EN
        check("bubble_seen", 64'(bubbles > 0), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
